// File: rtl/cv32e40p_ft_breakage_monitor_pkg.sv
// Shared fault-tolerance definitions for the breakage monitors of the triplicated stages.
// Holds the degradation state encoding and the per-unit monitor parameter sets.
package cv32e40p_ft_breakage_monitor_pkg;

   typedef enum logic [1:0] {
      BM_NORMAL   = 2'd0,
      BM_DEGRADED = 2'd1,
      BM_FAILED   = 2'd2
   } ft_bm_state_e;

   // Compressed-decoder voter monitor
   localparam int unsigned CDEC_INCREMENT          = 1;
   localparam int unsigned CDEC_DECREMENT          = 1;
   localparam int unsigned CDEC_BREAKING_THRESHOLD = 3;
   localparam int unsigned CDEC_COUNT_BIT          = 8;
   localparam int unsigned CDEC_INC_DEC_BIT        = 2;

   // Aligner voter monitor
   localparam int unsigned ALIG_INCREMENT          = 1;
   localparam int unsigned ALIG_DECREMENT          = 1;
   localparam int unsigned ALIG_BREAKING_THRESHOLD = 3;
   localparam int unsigned ALIG_COUNT_BIT          = 8;
   localparam int unsigned ALIG_INC_DEC_BIT        = 2;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Saturating up/down score counter with enable, clear and freeze.
// count_next is the value the register takes on the next edge, used for threshold checks.
module cv32e40p_ft_sat_counter
   import cv32e40p_ft_breakage_monitor_pkg::*;
#(
   parameter int unsigned COUNT_BIT   = 8,
   parameter int unsigned INC_DEC_BIT = 2,
   parameter int unsigned INCREMENT   = 1,
   parameter int unsigned DECREMENT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 up,
   input  logic                 clear,
   input  logic                 freeze,
   output logic [COUNT_BIT-1:0] count,
   output logic [COUNT_BIT-1:0] count_next
);

   localparam logic [INC_DEC_BIT-1:0] INC_OP  = INC_DEC_BIT'(INCREMENT);
   localparam logic [INC_DEC_BIT-1:0] DEC_OP  = INC_DEC_BIT'(DECREMENT);
   localparam logic [COUNT_BIT:0]     INC_EXT = (COUNT_BIT+1)'(INC_OP);
   localparam logic [COUNT_BIT:0]     DEC_EXT = (COUNT_BIT+1)'(DEC_OP);

   logic [COUNT_BIT:0] sum;
   logic [COUNT_BIT:0] diff;

   // One extra bit catches both overflow (carry out) and underflow (borrow wraps the MSB)
   always_comb begin
      sum        = {1'b0, count} + INC_EXT;
      diff       = {1'b0, count} - DEC_EXT;
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (en && !freeze) begin
         if (up) begin
            count_next = sum[COUNT_BIT] ? '1 : sum[COUNT_BIT-1:0];
         end else begin
            count_next = diff[COUNT_BIT] ? '0 : diff[COUNT_BIT-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/cv32e40p_ft_breakage_monitor.sv
// Leaky-bucket breakage monitor for a TMR stage: per-replica scores, sticky broken flags
// and a NORMAL/DEGRADED/FAILED degradation state machine with no-majority detection.
module cv32e40p_ft_breakage_monitor
   import cv32e40p_ft_breakage_monitor_pkg::*;
#(
   parameter int unsigned INCREMENT          = 1,
   parameter int unsigned DECREMENT          = 1,
   parameter int unsigned BREAKING_THRESHOLD = 3,
   parameter int unsigned COUNT_BIT          = 8,
   parameter int unsigned INC_DEC_BIT        = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   err_valid_i,
   input  logic [2:0]             err_i,
   input  logic                   clear_i,
   output logic [2:0]             broken_o,
   output logic [1:0]             state_o,
   output logic                   fatal_o,
   output logic                   nomaj_o,
   output logic [3*COUNT_BIT-1:0] count_o
);

   localparam logic [COUNT_BIT:0] THRESH = (COUNT_BIT+1)'(BREAKING_THRESHOLD);

   ft_bm_state_e        state_q, state_next;
   logic [2:0]          broken_q, broken_next;
   logic                nomaj_q, nomaj_next;
   logic                fatal_q, fatal_next;
   logic                nomaj_evt;
   logic                upd_en;
   logic [COUNT_BIT-1:0] cnt_q    [3];
   logic [COUNT_BIT-1:0] cnt_next [3];

   for (genvar k = 0; k < 3; k++) begin : g_replica
      cv32e40p_ft_sat_counter #(
         .COUNT_BIT  (COUNT_BIT),
         .INC_DEC_BIT(INC_DEC_BIT),
         .INCREMENT  (INCREMENT),
         .DECREMENT  (DECREMENT)
      ) u_counter (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (upd_en),
         .up        (err_i[k]),
         .clear     (clear_i),
         .freeze    (broken_q[k]),
         .count     (cnt_q[k]),
         .count_next(cnt_next[k])
      );
      assign count_o[k*COUNT_BIT +: COUNT_BIT] = cnt_q[k];
   end

   // With one replica masked, both survivors disagreeing leaves nothing to vote with
   always_comb begin
      nomaj_evt = 1'b0;
      if (err_valid_i) begin
         if (state_q == BM_NORMAL) begin
            nomaj_evt = (err_i == 3'b111);
         end else if (state_q == BM_DEGRADED) begin
            nomaj_evt = ((err_i & ~broken_q) == ~broken_q);
         end
      end
      upd_en = err_valid_i && (state_q != BM_FAILED) && !nomaj_evt;
   end

   always_comb begin
      broken_next = broken_q;
      for (int k = 0; k < 3; k++) begin
         if (upd_en && !clear_i && !broken_q[k] && ({1'b0, cnt_next[k]} >= THRESH)) begin
            broken_next[k] = 1'b1;
         end
      end

      state_next = state_q;
      case (state_q)
         BM_NORMAL: begin
            if (popcount3(broken_next) >= 2'd2)      state_next = BM_FAILED;
            else if (popcount3(broken_next) == 2'd1) state_next = BM_DEGRADED;
         end
         BM_DEGRADED: begin
            if (nomaj_evt || (popcount3(broken_next) >= 2'd2)) state_next = BM_FAILED;
         end
         BM_FAILED: state_next = BM_FAILED;
         default:   state_next = BM_FAILED;
      endcase

      nomaj_next = nomaj_evt;
      fatal_next = (state_next == BM_FAILED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BM_NORMAL;
         broken_q <= '0;
         nomaj_q  <= 1'b0;
         fatal_q  <= 1'b0;
      end else begin
         state_q  <= state_next;
         broken_q <= broken_next;
         nomaj_q  <= nomaj_next;
         fatal_q  <= fatal_next;
      end
   end

   assign broken_o = broken_q;
   assign state_o  = state_q;
   assign fatal_o  = fatal_q;
   assign nomaj_o  = nomaj_q;

endmodule

// File: tb/tb_cv32e40p_ft_breakage_monitor.sv
// Directed self-checking bench for the breakage monitor, with a narrow-counter
// second instance for saturation behaviour.
module tb_cv32e40p_ft_breakage_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_valid = 1'b0;
   logic [2:0]  err = 3'b000;
   logic        clear = 1'b0;
   logic [2:0]  broken;
   logic [1:0]  state;
   logic        fatal;
   logic        nomaj;
   logic [23:0] count;

   logic        s_valid = 1'b0;
   logic [2:0]  s_err = 3'b000;
   logic        s_clear = 1'b0;
   logic [2:0]  s_broken;
   logic [1:0]  s_state;
   logic        s_fatal;
   logic        s_nomaj;
   logic [5:0]  s_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e40p_ft_breakage_monitor dut (
      .clk(clk), .rst_n(rst_n), .err_valid_i(err_valid), .err_i(err), .clear_i(clear),
      .broken_o(broken), .state_o(state), .fatal_o(fatal), .nomaj_o(nomaj), .count_o(count)
   );

   cv32e40p_ft_breakage_monitor #(
      .INCREMENT(2), .DECREMENT(1), .BREAKING_THRESHOLD(3), .COUNT_BIT(2), .INC_DEC_BIT(2)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .err_valid_i(s_valid), .err_i(s_err), .clear_i(s_clear),
      .broken_o(s_broken), .state_o(s_state), .fatal_o(s_fatal), .nomaj_o(s_nomaj), .count_o(s_count)
   );

   task automatic do_reset();
      err_valid = 1'b0; err = 3'b000; clear = 1'b0;
      s_valid = 1'b0; s_err = 3'b000; s_clear = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic step(input logic v, input logic [2:0] e, input logic c);
      err_valid = v; err = e; clear = c;
      @(posedge clk); #1;
      err_valid = 1'b0; err = 3'b000; clear = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 24'h0) begin errors++; $display("FAIL reset_count: got %h expected %h", count, 24'h0); end
      checks++; if (broken !== 3'b000) begin errors++; $display("FAIL reset_broken: got %b expected 000", broken); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (fatal !== 1'b0 || nomaj !== 1'b0) begin errors++; $display("FAIL reset_flags: got fatal=%b nomaj=%b expected 0 0", fatal, nomaj); end
   endtask

   task automatic test_increments();
      logic [23:0] exp_c [3] = '{24'h000001, 24'h000002, 24'h000003};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'b001, 1'b0);
         checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL inc_count[%0d]: got %h expected %h", i, count, exp_c[i]); end
         if (i < 2) begin
            checks++; if (broken !== 3'b000) begin errors++; $display("FAIL inc_early_broken[%0d]: got %b expected 000", i, broken); end
         end
      end
      checks++; if (broken !== 3'b001) begin errors++; $display("FAIL inc_broken: got %b expected 001", broken); end
      checks++; if (state !== 2'd1 || fatal !== 1'b0) begin errors++; $display("FAIL inc_state: got %0d/%b expected 1/0", state, fatal); end
      // clear zeroes scores but keeps the broken flag and state
      step(1'b0, 3'b000, 1'b1);
      checks++; if (count !== 24'h0 || broken !== 3'b001 || state !== 2'd1) begin
         errors++; $display("FAIL clear_keeps: got count=%h broken=%b state=%0d expected 0 001 1", count, broken, state); end
      // a broken replica's mismatches are ignored
      step(1'b1, 3'b001, 1'b0);
      checks++; if (count !== 24'h0) begin errors++; $display("FAIL frozen_broken: got %h expected 0", count); end
   endtask

   task automatic test_decay();
      logic [2:0] pat [6] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
      logic [7:0] exp_c1 [6] = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, pat[i], 1'b0);
         checks++; if (count !== {8'd0, exp_c1[i], 8'd0}) begin
            errors++; $display("FAIL decay_count[%0d]: got %h expected %h", i, count, {8'd0, exp_c1[i], 8'd0}); end
      end
      checks++; if (broken !== 3'b000 || state !== 2'd0) begin errors++; $display("FAIL decay_nobreak: got %b/%0d expected 000/0", broken, state); end
      // err_i ignored while not valid
      step(1'b0, 3'b111, 1'b0);
      checks++; if (count !== 24'h0 || nomaj !== 1'b0) begin errors++; $display("FAIL invalid_ignored: got %h/%b expected 0/0", count, nomaj); end
   endtask

   task automatic test_saturation();
      do_reset();
      s_valid = 1'b1; s_err = 3'b001;
      @(posedge clk); #1;
      checks++; if (s_count !== 6'd2 || s_broken !== 3'b000) begin errors++; $display("FAIL sat_first: got %h/%b expected 02/000", s_count, s_broken); end
      @(posedge clk); #1;
      checks++; if (s_count !== 6'd3) begin errors++; $display("FAIL sat_clamp: got %h expected 03", s_count); end
      checks++; if (s_broken !== 3'b001 || s_state !== 2'd1) begin errors++; $display("FAIL sat_broken: got %b/%0d expected 001/1", s_broken, s_state); end
      @(posedge clk); #1;
      checks++; if (s_count !== 6'd3) begin errors++; $display("FAIL sat_hold: got %h expected 03", s_count); end
      s_valid = 1'b0; s_err = 3'b000;
   endtask

   task automatic test_nomaj();
      do_reset();
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b111, 1'b0);
      checks++; if (nomaj !== 1'b1 || count !== 24'h000001) begin errors++; $display("FAIL nomaj_normal: got %b/%h expected 1/000001", nomaj, count); end
      step(1'b0, 3'b000, 1'b0);
      checks++; if (nomaj !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL nomaj_pulse: got %b/%0d expected 0/0", nomaj, state); end
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      checks++; if (broken !== 3'b001 || state !== 2'd1) begin errors++; $display("FAIL nomaj_setup: got %b/%0d expected 001/1", broken, state); end
      step(1'b1, 3'b110, 1'b0);
      checks++; if (state !== 2'd2 || fatal !== 1'b1 || nomaj !== 1'b1) begin
         errors++; $display("FAIL nomaj_degraded: got state=%0d fatal=%b nomaj=%b expected 2 1 1", state, fatal, nomaj); end
      step(1'b1, 3'b010, 1'b0);
      checks++; if (nomaj !== 1'b0 || count !== 24'h000003 || state !== 2'd2) begin
         errors++; $display("FAIL failed_frozen: got nomaj=%b count=%h state=%0d expected 0 000003 2", nomaj, count, state); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(1'b1, 3'b011, 1'b0);
      step(1'b1, 3'b011, 1'b0);
      checks++; if (count !== 24'h000202) begin errors++; $display("FAIL simul_setup: got %h expected 000202", count); end
      step(1'b1, 3'b011, 1'b0);
      checks++; if (broken !== 3'b011 || state !== 2'd2 || fatal !== 1'b1) begin
         errors++; $display("FAIL simul_break: got broken=%b state=%0d fatal=%b expected 011 2 1", broken, state, fatal); end
   endtask

   task automatic test_clear_priority();
      do_reset();
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b001, 1'b1);
      checks++; if (count !== 24'h0 || broken !== 3'b000 || state !== 2'd0) begin
         errors++; $display("FAIL clear_priority: got count=%h broken=%b state=%0d expected 0 000 0", count, broken, state); end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (3) step(1'b1, 3'b001, 1'b0);
      repeat (2) step(1'b1, 3'b010, 1'b0);
      checks++; if (count !== 24'h000203 || broken !== 3'b001) begin errors++; $display("FAIL areset_setup: got %h/%b expected 000203/001", count, broken); end
      err_valid = 1'b1; err = 3'b010;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (count !== 24'h0 || broken !== 3'b000 || state !== 2'd0 || fatal !== 1'b0 || nomaj !== 1'b0) begin
         errors++; $display("FAIL areset_immediate: got count=%h broken=%b state=%0d fatal=%b nomaj=%b expected all 0", count, broken, state, fatal, nomaj); end
      @(posedge clk); #1;
      err_valid = 1'b0; err = 3'b000;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (count !== 24'h0 || state !== 2'd0) begin errors++; $display("FAIL areset_after: got %h/%0d expected 0/0", count, state); end
   endtask

   initial begin
      test_reset();
      test_increments();
      test_decay();
      test_saturation();
      test_nomaj();
      test_simultaneous();
      test_clear_priority();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cv32e40p_ft_breakage_monitor.md
# cv32e40p_ft_breakage_monitor

Breakage monitor for a triplicated (TMR) stage. It consumes the per-replica mismatch flags from the compressed-decoder voter, downstream of the aligner. It keeps a saturating leaky-bucket score per replica and declares a replica permanently broken once its score reaches the threshold. It also tracks a degradation state that the voter and the controller use to mask broken replicas and raise a fatal fault.

## Interface
- INCREMENT, 1: score added per valid cycle in which the replica mismatches.
- DECREMENT, 1: score subtracted per valid cycle in which the replica agrees.
- BREAKING_THRESHOLD, 3: score at or above which the replica is declared broken.
- COUNT_BIT, 8: score counter width.
- INC_DEC_BIT, 2: width of the INCREMENT/DECREMENT operands.
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- err_valid_i  in  1  voter comparison valid this cycle.
- err_i  in  3  bit k set means replica k disagrees with the majority.
- clear_i  in  1  synchronous clear of the scores only; broken flags and state are kept.
- broken_o  out  3  sticky broken flag per replica; the voter masks these replicas.
- state_o  out  2  degradation state: NORMAL=0, DEGRADED=1, FAILED=2.
- fatal_o  out  1  high when state_o is FAILED.
- nomaj_o  out  1  one-cycle pulse; the last valid cycle had no usable majority.
- count_o  out  3×COUNT_BIT  packed scores; replica k occupies bits [k*COUNT_BIT +: COUNT_BIT].

## Operation
- Reset values: all scores 0, broken_o=000, state_o=NORMAL, fatal_o=0, nomaj_o=0.
- Score update happens only when err_valid_i=1, and only for replicas that are not broken:
  - err_i[k]=1: score = min(score+INCREMENT, 2^COUNT_BIT−1).
  - err_i[k]=0: score = max(score−DECREMENT, 0).
  - Computation is done at COUNT_BIT+1 width and then saturated; there is no wrap-around.
- The score of a broken replica is frozen, and its err_i bit is ignored.
- No-majority condition:
  - In NORMAL, err_i=111 is a no-majority event. No score changes and nomaj_o pulses.
  - In DEGRADED, both surviving err bits set is a no-majority event. nomaj_o pulses and state goes to FAILED.
- Breakage: if the next score of replica k is ≥ BREAKING_THRESHOLD, broken_o[k] is set on the same edge as the score write. It stays set until rst_n.
- If two replicas cross the threshold on the same edge, both flags are set and state goes directly NORMAL→FAILED.
- State machine:
  - NORMAL→DEGRADED when exactly one replica is broken.
  - NORMAL/DEGRADED→FAILED when two or more replicas are broken, or on a DEGRADED no-majority event.
  - FAILED is absorbing until reset.
- clear_i=1 zeroes all scores and has priority over a simultaneous update. It does not change broken_o or state_o.
- In FAILED, scores freeze and nomaj_o stays 0.

## Timing
- All outputs are registered.
- Input cycle N is reflected in count_o, broken_o, state_o and nomaj_o after the rising edge ending cycle N; latency is 1 cycle.
- err_i is don't-care when err_valid_i=0.
- Assertion of rst_n at any point, including mid-update, returns all outputs to their reset values immediately; no partial update survives.
- There is no handshake back-pressure; the block accepts every cycle.

## Structure
- Shared FT package:
  - typedef enum logic [1:0] ft_bm_state_e {BM_NORMAL, BM_DEGRADED, BM_FAILED}.
  - The per-unit CDEC_/ALIG_ parameter sets, which are passed in at instantiation.
- Sub-module cv32e40p_ft_sat_counter: one saturating up/down counter with enable, clear and freeze. Instantiated three times.
- Threshold comparators and the FSM live in the top module.

## Test plan
- Increments to breakage: err_valid_i=1 with err_i=001 for 3 cycles → count_o[0] goes 1,2,3; broken_o=001 after the third edge; state_o=DEGRADED.
- Leaky decay and floor: err_i=010 for 2 cycles, then 000 for 4 cycles → count_o[1] goes 1,2,1,0,0,0. No breakage, and no underflow.
- Saturation with COUNT_BIT=2, BREAKING_THRESHOLD=3, INCREMENT=2:
  - Mismatches on a replica → score 2, then saturates at 3 instead of wrapping to 0.
  - broken_o for that replica is set on the edge the score reaches 3.
- No-majority handling:
  - err_i=111 in NORMAL → nomaj_o pulses for 1 cycle and the scores are unchanged.
  - After replica 0 is broken, err_i=110 → state_o=FAILED and fatal_o=1.
- Simultaneous breakage and clear:
  - Scores at 2,2,0, then err_i=011 → broken_o=011 and state goes directly to FAILED.
  - In another run, clear_i together with err_i=001 at score 2 → score 0 and no break.
- Async reset mid-run: drop rst_n between edges with scores at 2 and broken_o=001 → all outputs reset at once, and state_o returns to NORMAL.
